// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-stage responder with an in-order store buffer.
// Stores are queued and written back to a single-port RAM one per idle
// cycle. Loads get priority on the RAM port, forward from the youngest
// matching buffered store, and always respond exactly one cycle later.
module data_mem_responder #(
    parameter int DEPTH     = 4,
    parameter int MEM_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [4:0]  buf_count
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL = 5'(DEPTH);

    // Store buffer storage (no reset: occupancy is tracked by r_count)
    logic [AW-1:0] r_buf_idx  [DEPTH];
    logic [31:0]   r_buf_data [DEPTH];
    // Backing RAM, never cleared
    logic [31:0]   r_mem      [MEM_WORDS];

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [4:0]    r_count;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_rdata;

    logic          w_ready;
    logic          w_accept;
    logic          w_load_acc;
    logic          w_store_acc;
    logic          w_drain;
    logic [AW-1:0] w_idx;
    logic          w_fwd_hit;
    logic [31:0]   w_fwd_data;
    logic [31:0]   w_load_data;

    // Ready depends only on registered occupancy, never on req_* inputs.
    assign w_ready     = (r_count != FULL);
    // Requests arriving while reset is high are ignored entirely.
    assign w_accept    = req_valid & w_ready & ~reset;
    assign w_load_acc  = w_accept & ~req_write;
    assign w_store_acc = w_accept & req_write;
    // The single RAM port goes to loads first; drain only when nothing loads.
    assign w_drain     = (r_count != 5'd0) & ~w_load_acc & ~reset;
    assign w_idx       = req_addr[AW+1:2];

    // Scan buffered stores oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] w_pos;
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_pos      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_pos = r_head + PW'(i);
            if ((5'(i) < r_count) && (r_buf_idx[w_pos] == w_idx)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_buf_data[w_pos];
            end
        end
    end

    // Forwarded data overrides the (possibly stale) RAM word.
    assign w_load_data = w_fwd_hit ? w_fwd_data : r_mem[w_idx];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power of two).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_store_acc) r_tail <= r_tail + PW'(1);
            if (w_drain)     r_head <= r_head + PW'(1);
            case ({w_store_acc, w_drain})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Capture an accepted store at the tail slot.
    always_ff @(posedge clock) begin
        if (w_store_acc) begin
            r_buf_idx[r_tail]  <= w_idx;
            r_buf_data[r_tail] <= req_wdata;
        end
    end

    // Retire the head entry into RAM; gated by reset so undrained stores are lost.
    always_ff @(posedge clock) begin
        if (w_drain) begin
            r_mem[r_buf_idx[r_head]] <= r_buf_data[r_head];
        end
    end

    // One-cycle load response; data holds its value between responses.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_load_acc;
            if (w_load_acc) r_rsp_rdata <= w_load_data;
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign buf_count = r_count;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the store buffer.
module tb_data_mem_responder;

    localparam int DEPTH = 4;
    localparam int MW    = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  buf_count;

    int n_chk  = 0;
    int n_pass = 0;

    data_mem_responder #(.DEPTH(DEPTH), .MEM_WORDS(MW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .buf_count (buf_count)
    );

    always #5 clock = ~clock;

    // Reference model: FIFO of pending stores, a RAM image, expected response.
    typedef struct {
        logic [3:0]  idx;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_ram [MW];
    logic        exp_valid = 1'b0;
    logic [31:0] exp_rdata = '0;

    task automatic model_edge();
        bit          acc;
        bit          ld;
        logic [3:0]  idx;
        logic [31:0] val;
        ent_t        e;
        if (reset) begin
            m_q.delete();
            exp_valid = 1'b0;
            exp_rdata = '0;
        end else begin
            acc = req_valid && (m_q.size() != DEPTH);
            ld  = acc && !req_write;
            idx = req_addr[5:2];
            val = m_ram[idx];
            foreach (m_q[k]) if (m_q[k].idx == idx) val = m_q[k].data;
            exp_valid = ld;
            if (ld) exp_rdata = val;
            if (!ld && m_q.size() > 0) begin
                m_ram[m_q[0].idx] = m_q[0].data;
                void'(m_q.pop_front());
            end
            if (acc && req_write) begin
                e.idx  = idx;
                e.data = req_wdata;
                m_q.push_back(e);
            end
        end
    endtask

    // Apply one request for one clock; outputs are observed 1 time unit later.
    task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1, 1, 32'h10, 32'h55);
        step(1, 0, 32'h10, 32'h0);
        n_chk++; if (buf_count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", buf_count); else n_pass++;
        n_chk++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else n_pass++;
        n_chk++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); else n_pass++;
        reset = 1'b0;
        step(0, 0, 0, 0);
        n_chk++; if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", req_ready); else n_pass++;
        n_chk++; if (buf_count !== 5'd0) $display("FAIL reset_ignored_store got=%0d exp=0", buf_count); else n_pass++;
    endtask

    // Fill every RAM word so later loads have defined contents, then read back.
    task automatic test_init();
        for (int i = 0; i < MW; i++) step(1, 1, 32'(i * 4), $urandom);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        n_chk++; if (buf_count !== 5'd0) $display("FAIL init_drained got=%0d exp=0", buf_count); else n_pass++;
        for (int i = 0; i < MW; i++) begin
            step(1, 0, 32'(i * 4), 0);
            n_chk++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== m_ram[i])
                $display("FAIL init_readback word=%0d got=%b/%h exp=1/%h", i, rsp_valid, rsp_rdata, m_ram[i]);
            else n_pass++;
        end
    endtask

    task automatic test_store_then_load();
        step(1, 1, 32'h10, 32'hDEADBEEF);
        n_chk++; if (buf_count !== 5'd1) $display("FAIL sl_count_after_store got=%0d exp=1", buf_count); else n_pass++;
        step(0, 0, 0, 0);
        n_chk++; if (buf_count !== 5'd0) $display("FAIL sl_count_after_idle got=%0d exp=0", buf_count); else n_pass++;
        n_chk++; if (rsp_valid !== 1'b0) $display("FAIL sl_idle_rsp_valid got=%b exp=0", rsp_valid); else n_pass++;
        step(0, 0, 0, 0);
        step(1, 0, 32'h10, 0);
        n_chk++; if (rsp_valid !== 1'b1) $display("FAIL sl_rsp_valid got=%b exp=1", rsp_valid); else n_pass++;
        n_chk++; if (rsp_rdata !== 32'hDEADBEEF) $display("FAIL sl_rsp_rdata got=%h exp=deadbeef", rsp_rdata); else n_pass++;
        step(0, 0, 0, 0);
        n_chk++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF)
            $display("FAIL sl_rsp_hold got=%b/%h exp=0/deadbeef", rsp_valid, rsp_rdata); else n_pass++;
    endtask

    task automatic test_youngest_forward();
        step(1, 1, 32'h20, 32'h1);
        step(1, 1, 32'h20, 32'h2);
        n_chk++; if (buf_count !== 5'd1) $display("FAIL yf_count got=%0d exp=1", buf_count); else n_pass++;
        step(1, 0, 32'h20, 0);
        n_chk++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h2)
            $display("FAIL yf_rdata got=%b/%h exp=1/2", rsp_valid, rsp_rdata); else n_pass++;
        n_chk++; if (buf_count !== 5'd1) $display("FAIL yf_count_held_on_load got=%0d exp=1", buf_count); else n_pass++;
        step(0, 0, 0, 0);
        step(1, 0, 32'h20, 0);
        n_chk++; if (rsp_rdata !== 32'h2) $display("FAIL yf_ram_final got=%h exp=2", rsp_rdata); else n_pass++;
    endtask

    task automatic test_interleave();
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 32'h30 + 32'(i * 4), 32'h100 + 32'(i));
            n_chk++; if (buf_count !== 5'(m_q.size()) || req_ready !== 1'b1)
                $display("FAIL il_store%0d got=%0d/%b exp=%0d/1", i, buf_count, req_ready, m_q.size()); else n_pass++;
            step(1, 0, 32'h04, 0);
            n_chk++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata)
                $display("FAIL il_load%0d got=%b/%h exp=1/%h", i, rsp_valid, rsp_rdata, exp_rdata); else n_pass++;
        end
        step(0, 0, 0, 0);
        n_chk++; if (buf_count !== 5'(m_q.size()) || req_ready !== 1'b1)
            $display("FAIL il_drain got=%0d/%b exp=%0d/1", buf_count, req_ready, m_q.size()); else n_pass++;
    endtask

    task automatic test_byte_offset();
        logic [31:0] ram28;
        step(1, 1, 32'h24, 32'hA);
        step(1, 0, 32'h27, 0);
        n_chk++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA)
            $display("FAIL bo_alias got=%b/%h exp=1/a", rsp_valid, rsp_rdata); else n_pass++;
        ram28 = m_ram[10];
        step(1, 0, 32'h28, 0);
        n_chk++; if (rsp_rdata !== ram28) $display("FAIL bo_neighbor got=%h exp=%h", rsp_rdata, ram28); else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] prior_b;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        prior_b = m_ram[13];
        step(1, 1, 32'h30, 32'hAAAA0001);
        step(1, 1, 32'h34, 32'hBBBB0002);
        step(1, 0, 32'h34, 0);
        n_chk++; if (buf_count !== 5'd1) $display("FAIL rmd_pending got=%0d exp=1", buf_count); else n_pass++;
        reset = 1'b1;
        step(1, 1, 32'h34, 32'hCCCC0003);
        n_chk++; if (buf_count !== 5'd0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0)
            $display("FAIL rmd_cleared got=%0d/%b/%h exp=0/0/0", buf_count, rsp_valid, rsp_rdata); else n_pass++;
        reset = 1'b0;
        step(1, 0, 32'h34, 0);
        n_chk++; if (rsp_rdata !== prior_b) $display("FAIL rmd_discarded got=%h exp=%h", rsp_rdata, prior_b); else n_pass++;
        step(1, 0, 32'h30, 0);
        n_chk++; if (rsp_rdata !== 32'hAAAA0001) $display("FAIL rmd_drained got=%h exp=aaaa0001", rsp_rdata); else n_pass++;
    endtask

    task automatic test_store_and_drain();
        step(1, 1, 32'h3C, 32'h11);
        step(1, 1, 32'h3C, 32'h22);
        n_chk++; if (buf_count !== 5'd1) $display("FAIL sd_count_unchanged got=%0d exp=1", buf_count); else n_pass++;
        step(0, 0, 0, 0);
        step(1, 0, 32'h3C, 0);
        n_chk++; if (rsp_rdata !== 32'h22) $display("FAIL sd_order got=%h exp=22", rsp_rdata); else n_pass++;
    endtask

    task automatic test_random();
        logic v, w;
        for (int c = 0; c < 300; c++) begin
            reset = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1);
            step(v, w, {$urandom} & 32'h0000_003F, $urandom);
            n_chk++;
            if (rsp_valid !== exp_valid || rsp_rdata !== exp_rdata ||
                buf_count !== 5'(m_q.size()) || req_ready !== (m_q.size() != DEPTH))
                $display("FAIL rand c=%0d got v=%b d=%h n=%0d r=%b exp v=%b d=%h n=%0d",
                         c, rsp_valid, rsp_rdata, buf_count, req_ready, exp_valid, exp_rdata, m_q.size());
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init();
        test_store_then_load();
        test_youngest_forward();
        test_interleave();
        test_byte_offset();
        test_reset_mid_drain();
        test_store_and_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
